// File: rtl/id_ex_if.sv
// ID-to-EX stage bundle: decoded operands and controls from ID, registered ALU
// slice controls and pipeline controls back out of EX.
interface id_ex_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          ex_stall;
  logic          ex_flush;
  logic          id_valid;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic [RW-1:0] id_rd_addr;
  logic [1:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;

  logic          ex_valid;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_rt_data;
  logic [2:0]    ex_alu_sig;
  logic          ex_inv;
  logic          ex_shift;
  logic [4:0]    ex_shamt;
  logic [RW-1:0] ex_rd_addr;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          ex_illegal;

  modport master (
    output ex_stall, ex_flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
           id_rd_addr, id_alu_op, id_funct, id_alu_src, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg,
    input  ex_valid, ex_a, ex_b, ex_rt_data, ex_alu_sig, ex_inv, ex_shift, ex_shamt,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
  );

  modport slave (
    input  ex_stall, ex_flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
           id_rd_addr, id_alu_op, id_funct, id_alu_src, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg,
    output ex_valid, ex_a, ex_b, ex_rt_data, ex_alu_sig, ex_inv, ex_shift, ex_shamt,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
  );
endinterface

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register for the 1-bit-slice ripple ALU: latches operands and
// controls, and translates ALUOp/funct into the slice mux select and invert.
module id_ex_alu_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  id_ex_if.slave  bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] rt_data;
    logic [2:0]    sig;
    logic          inv;
    logic          shift;
    logic [4:0]    shamt;
    logic [RW-1:0] rd_addr;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          illegal;
  } stage_t;

  // Returns {sig[2:0], inv, shift, illegal}
  function automatic logic [5:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [5:0] r;
    case (op)
      2'b00: r = {3'b010, 1'b0, 1'b0, 1'b0};
      2'b01: r = {3'b010, 1'b1, 1'b0, 1'b0};
      2'b11: r = {3'b011, 1'b1, 1'b0, 1'b0};
      2'b10: begin
        case (funct)
          6'b100000: r = {3'b010, 1'b0, 1'b0, 1'b0};
          6'b100010: r = {3'b010, 1'b1, 1'b0, 1'b0};
          6'b100100: r = {3'b000, 1'b0, 1'b0, 1'b0};
          6'b100101: r = {3'b001, 1'b0, 1'b0, 1'b0};
          6'b101010: r = {3'b011, 1'b1, 1'b0, 1'b0};
          6'b000010: r = {3'b000, 1'b0, 1'b1, 1'b0};
          default:   r = {3'b000, 1'b0, 1'b0, 1'b1};
        endcase
      end
      default: r = {3'b000, 1'b0, 1'b0, 1'b1};
    endcase
    return r;
  endfunction

  stage_t     st_d;
  stage_t     st_q;
  logic [5:0] dec_s;

  // Next-state: flush beats stall; an empty ID slot loads as a bubble
  always_comb begin
    st_d  = st_q;
    dec_s = alu_decode(bus.id_alu_op, bus.id_funct);
    if (bus.ex_flush) begin
      st_d = '0;
    end else if (bus.ex_stall) begin
      st_d = st_q;
    end else if (!bus.id_valid) begin
      st_d = '0;
    end else begin
      st_d.valid   = 1'b1;
      st_d.a       = bus.id_rs_data;
      st_d.b       = bus.id_alu_src ? bus.id_imm : bus.id_rt_data;
      st_d.rt_data = bus.id_rt_data;
      st_d.sig     = dec_s[5:3];
      st_d.inv     = dec_s[2];
      st_d.shift   = dec_s[1];
      st_d.illegal = dec_s[0];
      st_d.shamt   = bus.id_shamt;
      st_d.rd_addr = bus.id_rd_addr;
      // An illegal funct still occupies the slot but must not touch state
      if (dec_s[0]) begin
        st_d.reg_write  = 1'b0;
        st_d.mem_read   = 1'b0;
        st_d.mem_write  = 1'b0;
        st_d.mem_to_reg = 1'b0;
      end else begin
        st_d.reg_write  = bus.id_reg_write;
        st_d.mem_read   = bus.id_mem_read;
        st_d.mem_write  = bus.id_mem_write;
        st_d.mem_to_reg = bus.id_mem_to_reg;
      end
    end
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign bus.ex_valid      = st_q.valid;
  assign bus.ex_a          = st_q.a;
  assign bus.ex_b          = st_q.b;
  assign bus.ex_rt_data    = st_q.rt_data;
  assign bus.ex_alu_sig    = st_q.sig;
  assign bus.ex_inv        = st_q.inv;
  assign bus.ex_shift      = st_q.shift;
  assign bus.ex_shamt      = st_q.shamt;
  assign bus.ex_rd_addr    = st_q.rd_addr;
  assign bus.ex_reg_write  = st_q.reg_write;
  assign bus.ex_mem_read   = st_q.mem_read;
  assign bus.ex_mem_write  = st_q.mem_write;
  assign bus.ex_mem_to_reg = st_q.mem_to_reg;
  assign bus.ex_illegal    = st_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Scoreboard bench for id_ex_alu_stage: expected EX contents are queued when ID
// stimulus is driven and compared one edge later.
module tb_id_ex_alu_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
    logic [2:0]  sig;
    logic        inv;
    logic        shift;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        ill;
  } ex_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  ex_t  sb[$];
  ex_t  last_exp;
  ex_t  exp_v;
  ex_t  obs_v;

  id_ex_if #(.DW(32), .RW(5)) bus ();

  id_ex_alu_stage #(.DW(32), .RW(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] legal_fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000010};
  logic [4:0] legal_ctl [6] = '{5'b01000, 5'b01010, 5'b00000, 5'b00100, 5'b01110, 5'b00001};

  function automatic ex_t observe();
    ex_t o;
    o = {bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_rt_data, bus.ex_alu_sig, bus.ex_inv,
         bus.ex_shift, bus.ex_shamt, bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read,
         bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_illegal};
    return o;
  endfunction

  // Expected EX contents for the values currently on the ID side
  function automatic ex_t model();
    ex_t        e;
    logic [4:0] ctl;
    logic       ill;
    e = '0;
    if (bus.ex_flush) return e;
    if (bus.ex_stall) return last_exp;
    if (!bus.id_valid) return e;
    ill = 1'b0;
    ctl = 5'b00000;
    if (bus.id_alu_op == 2'b00) ctl = 5'b01000;
    else if (bus.id_alu_op == 2'b01) ctl = 5'b01010;
    else if (bus.id_alu_op == 2'b11) ctl = 5'b01110;
    else begin
      ill = 1'b1;
      for (int k = 0; k < 6; k++) begin
        if (bus.id_funct == legal_fn[k]) begin
          ill = 1'b0;
          ctl = legal_ctl[k];
        end
      end
    end
    e.valid = 1'b1;
    e.a     = bus.id_rs_data;
    e.b     = bus.id_alu_src ? bus.id_imm : bus.id_rt_data;
    e.rt    = bus.id_rt_data;
    e.sig   = ctl[4:2];
    e.inv   = ctl[1];
    e.shift = ctl[0];
    e.shamt = bus.id_shamt;
    e.rd    = bus.id_rd_addr;
    e.ill   = ill;
    e.rw    = ill ? 1'b0 : bus.id_reg_write;
    e.mr    = ill ? 1'b0 : bus.id_mem_read;
    e.mw    = ill ? 1'b0 : bus.id_mem_write;
    e.m2r   = ill ? 1'b0 : bus.id_mem_to_reg;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic src, input logic [4:0] sh, input logic [4:0] rd,
                       input logic [3:0] ctl);
    bus.id_valid      = v;
    bus.id_alu_op     = op;
    bus.id_funct      = fn;
    bus.id_rs_data    = rs;
    bus.id_rt_data    = rt;
    bus.id_imm        = imm;
    bus.id_alu_src    = src;
    bus.id_shamt      = sh;
    bus.id_rd_addr    = rd;
    bus.id_reg_write  = ctl[3];
    bus.id_mem_read   = ctl[2];
    bus.id_mem_write  = ctl[1];
    bus.id_mem_to_reg = ctl[0];
  endtask

  task automatic push_and_tick();
    last_exp = model();
    sb.push_back(last_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 4'b0000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observe() !== ex_t'(0)) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", observe());
    end
    rst_n = 1'b1;
    last_exp = '0;
    drive(1'b1, 2'b10, 6'b100000, 32'h1234, 32'h55, 32'h9, 1'b0, 5'd2, 5'd9, 4'b1001);
    push_and_tick();
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL reset_preload got=%h exp=%h", obs_v, exp_v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (observe() !== ex_t'(0) || bus.ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = '0;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 4'b0000);
    @(posedge clk);
    #1;
  endtask

  task automatic test_sub();
    drive(1'b1, 2'b10, 6'b100010, 32'd7, 32'd3, 32'd100, 1'b0, 5'd0, 5'd4, 4'b1000);
    push_and_tick();
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL sub_sb got=%h exp=%h", obs_v, exp_v);
    end
    checks++;
    if (bus.ex_a !== 32'd7 || bus.ex_b !== 32'd3 || bus.ex_alu_sig !== 3'b010 ||
        bus.ex_inv !== 1'b1 || bus.ex_valid !== 1'b1 || bus.ex_reg_write !== 1'b1) begin
      failures++;
      $display("FAIL sub_fields got a=%0d b=%0d sig=%b inv=%b v=%b rw=%b exp 7 3 010 1 1 1",
               bus.ex_a, bus.ex_b, bus.ex_alu_sig, bus.ex_inv, bus.ex_valid, bus.ex_reg_write);
    end
  endtask

  task automatic test_load();
    drive(1'b1, 2'b00, 6'b111111, 32'h1000, 32'hABCD, 32'hFFFF_FFFC, 1'b1, 5'd0, 5'd8, 4'b0101);
    push_and_tick();
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL load_sb got=%h exp=%h", obs_v, exp_v);
    end
    checks++;
    if (bus.ex_b !== 32'hFFFF_FFFC || bus.ex_alu_sig !== 3'b010 || bus.ex_inv !== 1'b0 ||
        bus.ex_mem_read !== 1'b1 || bus.ex_rt_data !== 32'hABCD) begin
      failures++;
      $display("FAIL load_fields got b=%h sig=%b inv=%b mr=%b rt=%h exp fffffffc 010 0 1 abcd",
               bus.ex_b, bus.ex_alu_sig, bus.ex_inv, bus.ex_mem_read, bus.ex_rt_data);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 2'b10, 6'b101010, 32'd5, 32'd9, 32'd0, 1'b0, 5'd0, 5'd3, 4'b1000);
    push_and_tick();
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    if (obs_v !== exp_v || bus.ex_alu_sig !== 3'b011 || bus.ex_inv !== 1'b1) begin
      failures++;
      $display("FAIL slt_load got=%h exp=%h", obs_v, exp_v);
    end
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 2'b01, 6'b000010, $urandom, $urandom, $urandom, 1'b1, 5'd7, 5'd1, 4'b1111);
      push_and_tick();
      exp_v = sb.pop_front();
      obs_v = observe();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL stall_hold%0d got=%h exp=%h", i, obs_v, exp_v);
      end
    end
    bus.ex_flush = 1'b1;
    push_and_tick();
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    if (obs_v !== exp_v || bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 ||
        bus.ex_mem_write !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall got=%h exp=%h", obs_v, exp_v);
    end
    bus.ex_flush = 1'b0;
    bus.ex_stall = 1'b0;
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b10, 6'b111111, 32'd1, 32'd2, 32'd3, 1'b0, 5'd0, 5'd5, 4'b1011);
    push_and_tick();
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    if (obs_v !== exp_v || bus.ex_illegal !== 1'b1 || bus.ex_valid !== 1'b1 ||
        bus.ex_reg_write !== 1'b0 || bus.ex_mem_write !== 1'b0) begin
      failures++;
      $display("FAIL illegal got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_bubble_srl();
    drive(1'b0, 2'b00, 6'b100000, 32'd11, 32'd12, 32'd13, 1'b0, 5'd1, 5'd6, 4'b1000);
    push_and_tick();
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    if (obs_v !== exp_v || bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      failures++;
      $display("FAIL bubble got=%h exp=%h", obs_v, exp_v);
    end
    drive(1'b1, 2'b10, 6'b000010, 32'h0, 32'hF0, 32'h0, 1'b0, 5'd4, 5'd2, 4'b1000);
    push_and_tick();
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    if (obs_v !== exp_v || bus.ex_shift !== 1'b1 || bus.ex_shamt !== 5'd4 ||
        bus.ex_alu_sig !== 3'b000) begin
      failures++;
      $display("FAIL srl got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fn;
    for (int i = 0; i < 60; i++) begin
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 5)];
      bus.ex_stall = ($urandom_range(0, 3) == 0);
      bus.ex_flush = ($urandom_range(0, 7) == 0);
      drive(($urandom_range(0, 7) != 0), 2'($urandom), fn, $urandom, $urandom, $urandom,
            1'($urandom), 5'($urandom), 5'($urandom), 4'($urandom));
      push_and_tick();
      exp_v = sb.pop_front();
      obs_v = observe();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL b2b%0d got=%h exp=%h", i, obs_v, exp_v);
      end
    end
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_exp = '0;
    test_reset();
    test_sub();
    test_load();
    test_stall_flush();
    test_illegal();
    test_bubble_srl();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
